crc_frame_serializer: RTL and testbench
=======================================

Name: crc_frame_serializer

Overview:
- Upstream feeder for the bit-serial CRC calculator (`crc_calc`). It accepts bytes over a valid/ready handshake, buffers them in a small FIFO, and shifts each frame MSB-first as one contiguous bit stream.
- After the message it appends CRC_WIDTH zero augmentation bits. It drives the calculator's active-low reset between frames and captures the calculator's `crc_out` as the frame result.

Parameters:
- CRC_WIDTH, 8: width of the CRC; must match the downstream calculator.
- FIFO_DEPTH, 4: byte buffer depth in entries; power of two, ≥2.
- CAPTURE_LAT, 2: cycles from the last augmentation bit to a valid `crc_in`; 2 matches the calculator's registered output.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_data  in  8  message byte
- in_valid  in  1  byte valid
- in_last  in  1  byte is final byte of frame
- in_ready  out  1  FIFO can accept a byte
- crc_rst_n  out  1  to calculator `rst_n`; low holds/clears calculator
- bit_out  out  1  to calculator `data_in`
- bit_valid  out  1  bit_out carries frame bit (debug/monitor)
- crc_in  in  CRC_WIDTH  from calculator `crc_out`
- crc_result  out  CRC_WIDTH  captured CRC of last completed frame
- crc_done  out  1  one-cycle pulse, crc_result updated
- underrun  out  1  one-cycle pulse, frame aborted

Behaviour:
- Reset values:
  - FIFO emptied; state IDLE.
  - `crc_rst_n`=0, `bit_out`=0, `bit_valid`=0.
  - `crc_result`=0, `crc_done`=0, `underrun`=0.
  - `in_ready`=1 in the cycle after reset deasserts.
- Reset mid-frame discards the FIFO and the frame; no done or underrun pulse.
- Handshake: a byte is pushed when `in_valid && in_ready`.
  - `in_ready` = FIFO not full, in every state.
  - No bypass: when full, a same-cycle pop does not free the slot for a push.
  - Each entry stores {last, data}.
- All outputs are registered. `bit_out`=0 whenever `bit_valid`=0.
- The calculator shifts every cycle it is out of reset, so frame bits are never paused.
- States: IDLE, MSG, AUG, WAIT, FLUSH.
- IDLE:
  - Drives `crc_rst_n`=0, which also reloads the calculator's init value.
  - Starts when FIFO count == FIFO_DEPTH, or when any FIFO entry has last=1.
  - On start: pop head into the 8-bit shift register; bit_cnt=0; go to MSG.
- MSG:
  - `crc_rst_n`=1, `bit_valid`=1, `bit_out` = shift_reg[7]; shift left each cycle.
  - At bit_cnt==7, current byte last: go to AUG with aug_cnt=0.
  - At bit_cnt==7, not last, FIFO non-empty: pop into shift_reg, bit_cnt=0; bits stay contiguous with no gap cycle.
  - At bit_cnt==7, not last, FIFO empty: pulse `underrun`, `crc_rst_n`=0 next cycle, go to FLUSH.
- AUG:
  - `bit_out`=0, `bit_valid`=1 for exactly CRC_WIDTH cycles, then WAIT.
- WAIT:
  - `bit_valid`=0, `bit_out`=0, `crc_rst_n` stays 1 for CAPTURE_LAT cycles.
  - At the end of the last WAIT cycle, capture `crc_in` into `crc_result`.
  - The next cycle `crc_done`=1, and the block is in IDLE with `crc_rst_n`=0.
- FLUSH:
  - Pops FIFO entries as available until an entry with last=1 is popped, then IDLE.
  - A last byte already in the FIFO is popped in the first FLUSH cycle.
- Latency: the first `bit_valid` cycle is the cycle after the start condition. For an L-byte frame, `crc_done` is asserted 8L+CRC_WIDTH+CAPTURE_LAT cycles after the first `bit_valid` cycle.
- Back-to-back frames:
  - At least one IDLE cycle (calculator reset) separates frames.
  - Bytes of the next frame may be pushed during any state.
- Frame length is unbounded. A frame longer than FIFO_DEPTH needs in_valid to keep pace: one byte per 8 cycles.
- `crc_result` holds its value until the next `crc_done`; an underrun does not modify it.

Decomposition:
- Package `crc_pkg`:
  - Typedef `crc_ser_state_t` for the five states.
  - Localparam BYTE_W=8.
  - `fifo_entry_t` = {last, data[7:0]}.
- Sub-module `crc_byte_fifo`:
  - Parameter FIFO_DEPTH; synchronous, sync active-high reset.
  - Ports: push, pop, full, empty, count, head entry.
  - Exposes `any_last`: OR of the last flags of occupied entries.
- The FSM and shift/counter logic stay in `crc_frame_serializer`.

Test Plan:
- Setup for all scenarios: DUT wired to `crc_calc`, poly 0x07, init 0x00.
- Push single byte 0x01, last=1 → 8 MSG + 8 AUG cycles; `crc_done` 18 cycles after the first `bit_valid`; `crc_result`=0x07.
- Push ASCII "123456789" (0x31..0x39, last on 0x39) continuously → no underrun; `crc_result`=0xF4; `bit_valid` high for 80 contiguous cycles.
- FIFO_DEPTH=4: push 4 bytes without last, then stall → MSG starts on full; `underrun` pulses at the 32nd bit. Then push 0xAA, 0xBB(last) → both flushed, no `crc_done`, `crc_result` unchanged, IDLE.
- Two back-to-back frames (0x00,last) then (0x01,last), both pushed upfront → results 0x00 then 0x07; at least one `crc_rst_n`=0 cycle between them.
- Fill FIFO with `in_valid` held high → `in_ready`=0 when count==4; no byte lost or duplicated.
- Assert `rst` during AUG of frame 0x01 → all outputs return to reset values next cycle; no `crc_done`; a following frame 0x01 yields 0x07.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared types for the CRC frame serializer: FSM state encoding and FIFO entry layout.
package crc_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MSG,
    S_AUG,
    S_WAIT,
    S_FLUSH
  } crc_ser_state_t;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/crc_byte_fifo.sv
// Small synchronous byte FIFO storing {last, data}; also reports whether any
// occupied entry closes a frame, so the serializer can start short frames early.
module crc_byte_fifo
  import crc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned AW = $clog2(FIFO_DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  fifo_entry_t push_entry_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o,
  output fifo_entry_t head_o,
  output logic        any_last_o
);

  fifo_entry_t           mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]         wr_q, rd_q;
  logic [AW:0]           count_q;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];

  // No bypass: a full FIFO refuses a push even if the head is popped this cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    valid_d = valid_q;
    if (do_pop)  valid_d[rd_q] = 1'b0;
    if (do_push) valid_d[wr_q] = 1'b1;
  end

  always_comb begin
    any_last_o = 1'b0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      any_last_o = any_last_o | (valid_q[i] & mem_q[i].last);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      valid_q <= valid_d;
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (!do_push && do_pop) count_q <= count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_entry_i;
  end

endmodule

// File: rtl/crc_frame_serializer.sv
// Buffers framed bytes and feeds a bit-serial CRC calculator MSB-first with
// zero augmentation, managing the calculator reset and capturing its result.
module crc_frame_serializer
  import crc_pkg::*;
#(
  parameter int unsigned CRC_WIDTH   = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CAPTURE_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BYTE_W-1:0]    in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 crc_rst_n,
  output logic                 bit_out,
  output logic                 bit_valid,
  input  logic [CRC_WIDTH-1:0] crc_in,
  output logic [CRC_WIDTH-1:0] crc_result,
  output logic                 crc_done,
  output logic                 underrun
);

  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CNT_W      = 8;

  crc_ser_state_t        state_q, state_d;
  logic [BYTE_W-1:0]     shift_q, shift_d;
  logic                  cur_last_q, cur_last_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]      aug_cnt_q, aug_cnt_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic [CRC_WIDTH-1:0]  result_q, result_d;
  logic                  bit_out_q, bit_out_d;
  logic                  bit_valid_q, bit_valid_d;
  logic                  crc_rst_n_q, crc_rst_n_d;
  logic                  done_q, done_d;
  logic                  underrun_q, underrun_d;

  logic                  pop;
  logic                  fifo_full, fifo_empty, fifo_any_last;
  logic [FIFO_CNT_W-1:0] fifo_count;
  fifo_entry_t           fifo_head;
  logic                  start;

  crc_byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (in_valid),
    .push_entry_i('{last: in_last, data: in_data}),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .head_o      (fifo_head),
    .any_last_o  (fifo_any_last)
  );

  assign in_ready = !fifo_full;
  assign start    = (fifo_count == FIFO_CNT_W'(FIFO_DEPTH)) || fifo_any_last;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cur_last_d = cur_last_q;
    bit_cnt_d  = bit_cnt_q;
    aug_cnt_d  = aug_cnt_q;
    wait_cnt_d = wait_cnt_q;
    result_d   = result_q;
    pop        = 1'b0;
    done_d     = 1'b0;
    underrun_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pop        = 1'b1;
          shift_d    = fifo_head.data;
          cur_last_d = fifo_head.last;
          bit_cnt_d  = '0;
          state_d    = S_MSG;
        end
      end
      S_MSG: begin
        if (bit_cnt_q == 3'd7) begin
          if (cur_last_q) begin
            aug_cnt_d = '0;
            state_d   = S_AUG;
          end else if (!fifo_empty) begin
            pop        = 1'b1;
            shift_d    = fifo_head.data;
            cur_last_d = fifo_head.last;
            bit_cnt_d  = '0;
          end else begin
            underrun_d = 1'b1;
            state_d    = S_FLUSH;
          end
        end else begin
          shift_d   = {shift_q[BYTE_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      S_AUG: begin
        if (aug_cnt_q == CNT_W'(CRC_WIDTH - 1)) begin
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end else begin
          aug_cnt_d = aug_cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == CNT_W'(CAPTURE_LAT - 1)) begin
          result_d = crc_in;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_FLUSH: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (fifo_head.last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered copies of what the next state will drive.
    bit_valid_d = (state_d == S_MSG) || (state_d == S_AUG);
    bit_out_d   = (state_d == S_MSG) && shift_d[BYTE_W-1];
    crc_rst_n_d = bit_valid_d || (state_d == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      cur_last_q  <= 1'b0;
      bit_cnt_q   <= '0;
      aug_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      result_q    <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      crc_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cur_last_q  <= cur_last_d;
      bit_cnt_q   <= bit_cnt_d;
      aug_cnt_q   <= aug_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      result_q    <= result_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      crc_rst_n_q <= crc_rst_n_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
    end
  end

  assign crc_rst_n  = crc_rst_n_q;
  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign crc_result = result_q;
  assign crc_done   = done_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_crc_frame_serializer.sv
// Directed bench for crc_frame_serializer driving a behavioural bit-serial CRC-8
// calculator (poly 0x07, init 0x00); expected CRCs come from a byte-wise reference.
module tb_crc_frame_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid, in_last;
  logic       in_ready, crc_rst_n, bit_out, bit_valid;
  logic [7:0] crc_in, crc_result;
  logic       crc_done, underrun;

  always #5 clk = ~clk;

  crc_frame_serializer #(
    .CRC_WIDTH  (8),
    .FIFO_DEPTH (4),
    .CAPTURE_LAT(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .crc_rst_n (crc_rst_n),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .crc_in    (crc_in),
    .crc_result(crc_result),
    .crc_done  (crc_done),
    .underrun  (underrun)
  );

  // Calculator: shift register with a registered output stage.
  logic [7:0] calc_q, calc_out_q;
  always @(posedge clk) begin
    if (!crc_rst_n) begin
      calc_q     <= 8'h00;
      calc_out_q <= 8'h00;
    end else begin
      calc_q     <= {calc_q[6:0], bit_out} ^ (calc_q[7] ? 8'h07 : 8'h00);
      calc_out_q <= calc_q;
    end
  end
  assign crc_in = calc_out_q;

  typedef struct {
    logic [7:0]  crc;
    int unsigned len;
  } exp_t;
  exp_t sb[$];

  int passed = 0;
  int total  = 0;
  int failed = 0;

  int cyc = 0, first_valid_cyc = 0, run = 0, last_run = 0;
  int rise_cnt = 0, done_cnt = 0, underrun_cnt = 0, rstn_low = 0, last_gap = 0;
  logic prev_valid = 1'b0;

  logic [7:0]  acc = 8'h00;
  int unsigned flen = 0;
  logic        discard = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  // Monitor sampling 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    cyc++;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bit_valid && !prev_valid) begin
        first_valid_cyc = cyc;
        run             = 0;
        rise_cnt++;
        last_gap        = rstn_low;
      end
      if (bit_valid) run++;
      if (!bit_valid && prev_valid) last_run = run;
      if (!bit_valid) check("bit_out_idle", 32'(bit_out), 32'd0);
      if (crc_done) begin
        done_cnt++;
        rstn_low = 0;
        if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("crc_result", 32'(crc_result), 32'(e.crc));
          check("done_latency", 32'(cyc - first_valid_cyc), 32'(8 * e.len + 10));
        end
      end
      if (!crc_rst_n) rstn_low++;
      if (underrun) begin
        underrun_cnt++;
        check("underrun_pos", 32'(cyc - first_valid_cyc), 32'd32);
        check("underrun_rstn", 32'(crc_rst_n), 32'd0);
      end
      prev_valid = bit_valid;
    end
  end

  task automatic push_byte(input logic [7:0] d, input logic l);
    int g = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("push_wait", 32'(in_ready), 32'd1);
    acc = crc8_byte(acc, d);
    flen++;
    if (l) begin
      if (!discard) sb.push_back('{crc: acc, len: flen});
      acc  = 8'h00;
      flen = 0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int g = 0;
    while (done_cnt < target && g < 400) begin
      @(negedge clk);
      g++;
    end
    check("done_wait", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rstn"}, 32'(crc_rst_n), 32'd0);
    check({tag, "_bit_out"}, 32'(bit_out), 32'd0);
    check({tag, "_bit_valid"}, 32'(bit_valid), 32'd0);
    check({tag, "_result"}, 32'(crc_result), 32'd0);
    check({tag, "_done"}, 32'(crc_done), 32'd0);
    check({tag, "_underrun"}, 32'(underrun), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int g;
    int rises_before;
    rst      = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    // Single byte 0x01 -> 0x07, 8 MSG + 8 AUG bits.
    push_byte(8'h01, 1'b1);
    wait_done(1);
    check("run_len_1", 32'(last_run), 32'd16);

    // "123456789" -> 0xF4, 80 contiguous valid bits.
    for (int i = 0; i < 9; i++) push_byte(8'h31 + 8'(i), i == 8);
    wait_done(2);
    check("run_len_9", 32'(last_run), 32'd80);
    check("no_underrun", 32'(underrun_cnt), 32'd0);

    // Underrun: four bytes without last, then stall.
    discard = 1'b1;
    push_byte(8'h11, 1'b0);
    push_byte(8'h22, 1'b0);
    push_byte(8'h33, 1'b0);
    push_byte(8'h44, 1'b0);
    g = 0;
    while (underrun_cnt == 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("underrun_seen", 32'(underrun_cnt), 32'd1);
    check("run_len_underrun", 32'(last_run), 32'd32);
    rises_before = rise_cnt;
    push_byte(8'hAA, 1'b0);
    push_byte(8'hBB, 1'b1);
    discard = 1'b0;
    repeat (20) @(negedge clk);
    check("flush_no_done", 32'(done_cnt), 32'd2);
    check("flush_result_kept", 32'(crc_result), 32'hF4);
    check("flush_no_frame", 32'(rise_cnt), 32'(rises_before));
    check("flush_idle_rstn", 32'(crc_rst_n), 32'd0);
    check("flush_fifo_empty", 32'(in_ready), 32'd1);

    // Back-to-back frames pushed upfront.
    push_byte(8'h00, 1'b1);
    push_byte(8'h01, 1'b1);
    wait_done(4);
    check("b2b_rstn_gap", 32'(last_gap >= 1), 32'd1);

    // Fill FIFO with in_valid held high.
    push_byte(8'h10, 1'b0);
    push_byte(8'h20, 1'b0);
    push_byte(8'h30, 1'b0);
    push_byte(8'h40, 1'b0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    push_byte(8'h50, 1'b0);
    push_byte(8'h60, 1'b1);
    wait_done(5);
    check("run_len_6", 32'(last_run), 32'd56);

    // Reset during AUG of frame 0x01.
    rises_before = rise_cnt;
    push_byte(8'h01, 1'b1);
    g = 0;
    while (rise_cnt == rises_before && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("abort_frame_started", 32'(rise_cnt), 32'(rises_before + 1));
    repeat (10) @(negedge clk);
    rst = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    check_reset_outputs("midreset");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midreset_no_done", 32'(done_cnt), 32'd5);
    push_byte(8'h01, 1'b1);
    wait_done(6);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("underrun_total", 32'(underrun_cnt), 32'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
